// File: rtl/flow_ctrl_rx_pkg.sv
// Shared flow-control definitions for the GEMAC pause path.
package flow_ctrl_rx_pkg;
  localparam int          FC_QUANTA_BITS = 512;
  localparam logic [15:0] FC_XON_TIME    = 16'h0000;

  typedef enum logic {FC_IDLE, FC_PAUSED} fc_state_e;
endpackage

// File: rtl/flow_ctrl_rx_timer.sv
// Pause-quantum prescaler plus saturating quanta down-counter.
module fc_quanta_timer #(
  parameter int QUANTA_CLKS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        run,
  input  logic [15:0] value,
  output logic [15:0] quanta_next
);
  localparam int SUB_W = (QUANTA_CLKS > 1) ? $clog2(QUANTA_CLKS) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(QUANTA_CLKS - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic [15:0]      quanta_rem;
  logic             wrap;

  // quanta_next is what quanta_rem becomes at this edge, so the owner can
  // act on a quantum boundary without losing a cycle.
  always_comb begin
    wrap        = (sub_cnt == '0);
    quanta_next = (wrap && quanta_rem != 16'd0) ? quanta_rem - 16'd1 : quanta_rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sub_cnt    <= '0;
      quanta_rem <= 16'd0;
    end else if (load) begin
      sub_cnt    <= SUB_MAX;
      quanta_rem <= value;
    end else if (run) begin
      sub_cnt    <= wrap ? SUB_MAX : sub_cnt - 1'b1;
      quanta_rem <= quanta_next;
    end
  end
endmodule

// File: rtl/flow_ctrl_rx.sv
// RX-side flow control: issues XOFF/XON pause requests from RX FIFO free space
// and refreshes XOFF before the granted pause interval runs out.
module flow_ctrl_rx
  import flow_ctrl_rx_pkg::*;
#(
  parameter int QUANTA_CLKS = 64,
  parameter int SPACE_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_request_en,
  input  logic [15:0]        pause_time,
  input  logic [SPACE_W-1:0] pause_thresh,
  input  logic [SPACE_W-1:0] resume_thresh,
  input  logic [SPACE_W-1:0] fifo_space,
  output logic               pause_req,
  output logic [15:0]        pause_time_req,
  output logic               xoff_active
);
  fc_state_e          state;
  logic [15:0]        pt_lat;
  logic [15:0]        quanta_next;
  logic [SPACE_W-1:0] res_lvl;
  logic               go_xoff, go_xon, go_ref;

  // A pulse in flight blocks every decision for one cycle, so pause_req can
  // never be high on two consecutive clocks.
  always_comb begin
    res_lvl = (resume_thresh > pause_thresh) ? resume_thresh : pause_thresh;
    go_xoff = 1'b0;
    go_xon  = 1'b0;
    go_ref  = 1'b0;
    if (!pause_req) begin
      if (state == FC_IDLE)
        go_xoff = pause_request_en && (pause_time != FC_XON_TIME) &&
                  (fifo_space < pause_thresh);
      else if (!pause_request_en || fifo_space >= res_lvl)
        go_xon = 1'b1;
      else if (quanta_next <= (pt_lat >> 1))
        go_ref = 1'b1;
    end
  end

  fc_quanta_timer #(.QUANTA_CLKS(QUANTA_CLKS)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (go_xoff || go_ref),
    .clear       (go_xon),
    .run         (state == FC_PAUSED),
    .value       (pause_time),
    .quanta_next (quanta_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FC_IDLE;
      pause_req      <= 1'b0;
      pause_time_req <= 16'd0;
      xoff_active    <= 1'b0;
      pt_lat         <= 16'd0;
    end else begin
      pause_req <= go_xoff || go_xon || go_ref;
      if (go_xoff || go_ref) begin
        state          <= FC_PAUSED;
        xoff_active    <= 1'b1;
        pause_time_req <= pause_time;
        pt_lat         <= pause_time;
      end else if (go_xon) begin
        state          <= FC_IDLE;
        xoff_active    <= 1'b0;
        pause_time_req <= FC_XON_TIME;
        pt_lat         <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_flow_ctrl_rx.sv
// Directed plus randomized bench for flow_ctrl_rx against a cycle-level
// reference model of the pause/refresh/resume rules.
module tb_flow_ctrl_rx;
  localparam int Q = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pt = 16'd0;
  logic [15:0] pthr = 16'd0;
  logic [15:0] rthr = 16'd0;
  logic [15:0] space = 16'd0;
  logic        pause_req;
  logic [15:0] pause_time_req;
  logic        xoff_active;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int cyc = 0, npulse = 0;
  int ptimes[$];

  // reference model state
  bit m_paused = 0, m_req = 0;
  int m_time = 0, m_e = 0, m_lat = 0;

  always #4 clk = ~clk;

  flow_ctrl_rx #(.QUANTA_CLKS(Q), .SPACE_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pause_request_en(en),
    .pause_time     (pt),
    .pause_thresh   (pthr),
    .resume_thresh  (rthr),
    .fifo_space     (space),
    .pause_req      (pause_req),
    .pause_time_req (pause_time_req),
    .xoff_active    (xoff_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance the model on the same inputs the DUT samples, then compare.
  task automatic tick();
    bit cool;
    int res;
    @(posedge clk);
    if (!rst_n) begin
      m_paused = 0; m_req = 0; m_time = 0; m_e = 0; m_lat = 0;
    end else begin
      cool  = m_req;
      m_req = 0;
      res   = (int'(rthr) > int'(pthr)) ? int'(rthr) : int'(pthr);
      if (!m_paused) begin
        if (!cool && en && pt != 0 && int'(space) < int'(pthr)) begin
          m_req = 1; m_time = pt; m_lat = pt; m_e = 0; m_paused = 1;
        end
      end else begin
        m_e++;
        if (!cool) begin
          if (!en || int'(space) >= res) begin
            m_req = 1; m_time = 0; m_paused = 0;
          end else if (m_e >= ((m_lat + 1) / 2) * Q) begin
            m_req = 1; m_time = pt; m_lat = pt; m_e = 0;
          end
        end
      end
    end
    #1;
    chk("pause_req", pause_req, m_req);
    chk("pause_time_req", pause_time_req, m_time);
    chk("xoff_active", xoff_active, m_paused);
    if (pause_req) begin
      npulse++;
      ptimes.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset and idle
    run(5);
    chk("reset_req", pause_req, 0);
    chk("reset_time", pause_time_req, 0);
    chk("reset_xoff", xoff_active, 0);
    rst_n = 1; en = 1; pt = 16; pthr = 100; rthr = 500; space = 1000;
    npulse = 0;
    run(20);
    chk("idle_no_pulse", npulse, 0);

    // XOFF then XON
    space = 50;
    tick();
    chk("xoff_pulse", pause_req, 1);
    chk("xoff_time", pause_time_req, 16);
    chk("xoff_active_set", xoff_active, 1);
    space = 600; npulse = 0;
    run(6);
    chk("xon_one_pulse", npulse, 1);
    chk("xon_time", pause_time_req, 0);
    chk("xon_xoff_clear", xoff_active, 0);

    // refresh cadence at 8*64 clocks
    space = 50; npulse = 0; ptimes.delete();
    run(1100);
    chk("refresh_count", npulse, 3);
    if (ptimes.size() == 3) begin
      chk("refresh_gap1", ptimes[1] - ptimes[0], 512);
      chk("refresh_gap2", ptimes[2] - ptimes[1], 512);
    end
    chk("refresh_time", pause_time_req, 16);
    space = 1000;
    run(5);

    // resume_thresh below pause_thresh: resume level is pause_thresh
    pt = 100; pthr = 100; rthr = 20;
    for (int ph = 0; ph < 4; ph++) begin
      space = (ph % 2 == 0) ? 16'd99 : 16'd100;
      npulse = 0;
      run(1000);
      chk("toggle_pulses", npulse, 1);
      chk("toggle_xoff", xoff_active, (ph % 2 == 0) ? 1 : 0);
    end

    // enable drop while paused, then zero pause time
    pt = 16; rthr = 500; space = 50;
    run(10);
    en = 0;
    tick();
    chk("en_drop_xon", pause_req, 1);
    chk("en_drop_time", pause_time_req, 0);
    en = 1; pt = 0; space = 0; npulse = 0;
    run(20);
    chk("zero_time_no_pulse", npulse, 0);
    chk("zero_time_idle", xoff_active, 0);

    // reset mid-pause: outputs clear, no XON afterwards
    pt = 16; space = 50;
    run(5);
    chk("pre_reset_paused", xoff_active, 1);
    rst_n = 0;
    tick();
    chk("midrst_req", pause_req, 0);
    chk("midrst_time", pause_time_req, 0);
    chk("midrst_xoff", xoff_active, 0);
    rst_n = 1; space = 1000; npulse = 0;
    run(10);
    chk("midrst_no_xon", npulse, 0);

    // randomized traffic around the thresholds
    pthr = 16'($urandom_range(10, 40));
    rthr = 16'($urandom_range(0, 60));
    pt   = 16'($urandom_range(1, 6));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)   space = 16'($urandom_range(0, 70));
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0)  pt = 16'($urandom_range(1, 6));
      if ($urandom_range(0, 299) == 0) rthr = 16'($urandom_range(0, 60));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
